fifo_wr_arbiter: RTL and testbench

- Shares the write port of one async FIFO between NUM_REQ requesters in the write-clock domain.
- Each requester presents valid/ready/last beats. The block grants one requester at a time in round-robin order and locks the grant until that requester's burst ends.
- While the grant is held, the winner's beats are steered onto the FIFO's wr_en/din, and the block never writes while the FIFO reports full.
- Sits between crossbar master-side channel logic and the FIFO write side.

---
 rtl/fifo_wr_arbiter_if.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle for fifo_wr_arbiter.
// master: requester + FIFO side (drives beats and full), slave: the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;
    logic                          timeout_err;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din, grant_id, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async-FIFO write port.
// One idle cycle per grant; the winner's beats stream straight onto
// fifo_wr_en/fifo_din and never while fifo_full is high.
// Optional macro FIFO_WR_ARB_TIMEOUT_EN: release a grant whose owner has
// held valid low for IDLE_TIMEOUT cycles and pulse timeout_err.
module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [CNT_W-1:0] beat_cnt;
    logic             in_burst;

    logic [ID_W-1:0]  pick;
    logic             pick_vld;
    logic [ID_W-1:0]  ix;
    logic             g_valid;
    logic             g_last;
    logic             xfer;
    logic             burst_done;
    logic [ID_W-1:0]  next_rr;

    // First valid requester at or after rr_ptr, wrapping; the downward
    // loop lets the smallest offset win.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        ix       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            ix = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req_valid[ix]) begin
                pick     = ix;
                pick_vld = 1'b1;
            end
        end
    end

    assign g_valid    = bus.req_valid[grant_id];
    assign g_last     = bus.req_last[grant_id];
    assign xfer       = in_burst && g_valid && !bus.fifo_full;
    // Last beat and burst limit landing together still release just once.
    assign burst_done = g_last || (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign next_rr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    assign bus.req_ready  = (in_burst && !bus.fifo_full) ? (NUM_REQ'(1) << grant_id) : '0;
    assign bus.fifo_wr_en = xfer;
    assign bus.fifo_din   = in_burst ? bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.grant_id   = grant_id;
    assign bus.busy       = in_burst;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(IDLE_TIMEOUT + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               timeout_err;
    logic               stall_expired;

    assign stall_expired   = in_burst && !g_valid && (stall_cnt == STALL_W'(IDLE_TIMEOUT - 1));
    assign bus.timeout_err = timeout_err;

    // Stall counter only advances while the owner has valid low; a
    // fifo_full stall with valid high clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= stall_expired;
            if (!in_burst || g_valid || stall_expired)
                stall_cnt <= '0;
            else
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic stall_expired;

    assign stall_expired   = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Arbitration/burst FSM; grant_id stays on the last winner through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            in_burst <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id <= pick;
                        state    <= BURST;
                        in_burst <= 1'b1;
                    end
                end
                BURST: begin
                    if ((xfer && burst_done) || stall_expired) begin
                        state    <= IDLE;
                        in_burst <= 1'b0;
                        beat_cnt <= '0;
                        rr_ptr   <= next_rr;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_burst <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: drivers push every issued beat into
// a per-requester expected queue; a negedge monitor runs a grant-level
// reference model and pops/compares each FIFO write.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MB = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t src_q[NR][$];
    beat_t exp_q[NR][$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_wr   = 0;
    int n_to   = 0;
    int act_pct   = 10;  // tenths: chance a requester with data shows valid
    int full_mode = 1;   // 0 random, 1 forced low, 2 forced high
    int full_pct  = 3;
    logic [NR-1:0] hs;

    // reference model state
    int  m_gid   = 0;
    int  m_rr    = 0;
    int  m_cnt   = 0;
    int  m_stall = 0;
    bit  m_busy  = 0;
    bit  m_to    = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    task automatic push_beat(input int r, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[r].push_back(b);
        exp_q[r].push_back(b);
    endtask

    task automatic push_burst(input int r, input int len, input logic [DW-1:0] base);
        for (int b = 0; b < len; b++) push_beat(r, base + DW'(b), b == len - 1);
    endtask

    task automatic drive();
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*DW-1:0] d;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(0, 9) < act_pct) begin
                v[i] = 1'b1;
                d[i*DW +: DW] = src_q[i][0].data;
                l[i] = src_q[i][0].last;
            end else begin
                v[i] = 1'b0;
                d[i*DW +: DW] = DW'($urandom);
                l[i] = 1'($urandom);
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        case (full_mode)
            0:       bus.fifo_full = ($urandom_range(0, 9) < full_pct);
            2:       bus.fifo_full = 1'b1;
            default: bus.fifo_full = 1'b0;
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        hs = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive();
    endtask

    function automatic bit all_idle();
        bit e = !m_busy;
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 0;
        return e;
    endfunction

    task automatic drain(input string nm);
        int s = 0;
        while (!all_idle() && s < 3000) begin
            step();
            s++;
        end
        step();
        chk({nm, "_drained"}, all_idle(), 1);
    endtask

    function automatic int exp_left();
        int n = 0;
        for (int i = 0; i < NR; i++) n += exp_q[i].size();
        return n;
    endfunction

    // Reference model: grant chosen round-robin from the last finisher + 1,
    // burst ends on a written last beat or the MB-th beat.
    always @(negedge clk) begin
        logic [NR-1:0] er;
        bit full;
        bit found;
        beat_t e;
        if (rst) begin
            m_busy = 0; m_rr = 0; m_gid = 0; m_cnt = 0; m_stall = 0; m_to = 0;
        end else begin
            chk("timeout_err", bus.timeout_err, m_to);
            m_to = 0;
            chk("busy", bus.busy, m_busy);
            chk("grant_id", bus.grant_id, m_gid);
            full = bus.fifo_full;
            if (!m_busy) begin
                chk("ready_idle", bus.req_ready, 0);
                chk("wr_en_idle", bus.fifo_wr_en, 0);
                found = 0;
                for (int k = 0; k < NR; k++)
                    if (!found && bus.req_valid[(m_rr + k) % NR]) begin
                        m_gid  = (m_rr + k) % NR;
                        m_busy = 1;
                        found  = 1;
                    end
                m_cnt = 0;
                m_stall = 0;
            end else begin
                er = full ? '0 : NR'(1) << m_gid;
                chk("req_ready", bus.req_ready, er);
                chk("fifo_wr_en", bus.fifo_wr_en, bus.req_valid[m_gid] && !full);
                if (bus.req_valid[m_gid] && !full) begin
                    n_wr++;
                    if (exp_q[m_gid].size() == 0) chk("din_unexpected", 1, 0);
                    else begin
                        e = exp_q[m_gid].pop_front();
                        chk("fifo_din", bus.fifo_din, e.data);
                    end
                    m_stall = 0;
                    if (bus.req_last[m_gid] || m_cnt == MB - 1) begin
                        m_busy = 0;
                        m_rr = (m_gid + 1) % NR;
                        m_cnt = 0;
                    end else m_cnt++;
                end else if (bus.req_valid[m_gid]) begin
                    m_stall = 0;
                end else begin
`ifdef FIFO_WR_ARB_TIMEOUT_EN
                    if (m_stall == TO - 1) begin
                        m_busy = 0;
                        m_rr = (m_gid + 1) % NR;
                        m_cnt = 0;
                        m_stall = 0;
                        m_to = 1;
                        n_to++;
                    end else m_stall++;
`endif
                end
            end
        end
    end

    initial begin
        int w0;
        int s;
        rst = 1'b1;
        hs = '0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_wr_en", bus.fifo_wr_en, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_din", bus.fifo_din, 0);
        chk("rst_grant", bus.grant_id, 0);
        rst = 1'b0;

        // single burst, no contention
        w0 = n_wr;
        push_burst(2, 3, 16'h00A1);
        drive();
        drain("single");
        chk("single_writes", n_wr - w0, 3);

        // round-robin fairness with 1-beat bursts
        w0 = n_wr;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) push_burst(i, 1, DW'(16'h0100 * (i + 1) + r));
        drain("rr");
        chk("rr_writes", n_wr - w0, 8);

        // backpressure mid-burst
        w0 = n_wr;
        push_burst(1, 4, 16'h0B00);
        step(); step(); step();
        full_mode = 2;
        step(); step(); step();
        full_mode = 1;
        drain("full");
        chk("full_writes", n_wr - w0, 4);

        // MAX_BURST forced release and regrant
        w0 = n_wr;
        push_burst(0, 20, 16'h1000);
        drain("maxburst");
        chk("maxburst_writes", n_wr - w0, 20);

        // asynchronous reset mid-burst
        w0 = n_wr;
        push_burst(1, 5, 16'h0500);
        s = 0;
        while (n_wr - w0 < 2 && s < 50) begin
            step();
            s++;
        end
        chk("rst_reach_beat2", n_wr - w0, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_wr_en", bus.fifo_wr_en, 0);
        chk("arst_ready", bus.req_ready, 0);
        chk("arst_din", bus.fifo_din, 0);
        chk("arst_grant", bus.grant_id, 0);
        for (int i = 0; i < NR; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        bus.req_valid = '0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        push_burst(3, 2, 16'h0300);
        drive();
        drain("post_rst");

`ifdef FIFO_WR_ARB_TIMEOUT_EN
        // owner stalls after one beat while another requester waits
        w0 = n_to;
        push_beat(3, 16'h3333, 1'b0);
        s = 0;
        while (src_q[3].size() != 0 && s < 50) begin
            step();
            s++;
        end
        exp_q[3].delete();
        push_burst(0, 2, 16'h0A00);
        drain("timeout");
        chk("timeout_count", n_to - w0, 1);
        // full-only stall must never time out
        w0 = n_to;
        push_burst(1, 2, 16'h0700);
        step(); step();
        full_mode = 2;
        repeat (20) step();
        full_mode = 1;
        drain("full_stall");
        chk("no_timeout_on_full", n_to - w0, 0);
`endif

        // randomized contention with random backpressure
        w0 = n_wr;
        act_pct = 7;
        full_mode = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0)
                push_burst($urandom_range(0, NR - 1), $urandom_range(1, 20), DW'($urandom));
            step();
        end
        act_pct = 10;
        full_mode = 1;
        drain("random");
        chk("random_all_written", exp_left(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
